// File: rtl/ysyx_210238_csr_pkg.sv
// rtl/ysyx_210238_csr_pkg.sv - shared CSR addresses, op encodings, bit positions and masks
package ysyx_210238_csr_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int IRQ_MSI      = 3;
    localparam int IRQ_MTI      = 7;
    localparam int IRQ_MEI      = 11;
    localparam int CNT_CY       = 0;
    localparam int CNT_IR       = 2;

    localparam logic [63:0] MIE_MASK           = 64'h0000_0000_0000_0888;
    localparam logic [63:0] MCOUNTINHIBIT_MASK = 64'h0000_0000_0000_0005;

endpackage

// File: rtl/ysyx_210238_csr_counter.sv
// rtl/ysyx_210238_csr_counter.sv - 64-bit inhibitable counter with XLEN-sliced write
module ysyx_210238_csr_counter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            inhibit,
    input  logic            wr_lo,
    input  logic            wr_hi,
    input  logic [XLEN-1:0] wdata,
    output logic [63:0]     value
);

    logic [63:0] wdata_ext;
    logic [63:0] lo_mask;

    assign wdata_ext = 64'(wdata);
    assign lo_mask   = (XLEN == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;

    // A write always beats the increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (wr_hi) begin
            value <= {wdata_ext[31:0], value[31:0]};
        end else if (wr_lo) begin
            value <= (value & ~lo_mask) | (wdata_ext & lo_mask);
        end else if (inc && !inhibit) begin
            value <= value + 64'd1;
        end
    end

endmodule

// File: rtl/ysyx_210238_csr_unit.sv
// rtl/ysyx_210238_csr_unit.sv - machine-mode CSR file with trap entry, MRET and interrupt request
module ysyx_210238_csr_unit
    import ysyx_210238_csr_pkg::*;
#(
    parameter int          XLEN    = 64,
    parameter int unsigned HART_ID = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      i_csr_op,
    input  logic [11:0]     i_csr_addr,
    input  logic [XLEN-1:0] i_csr_wdata,
    output logic [XLEN-1:0] o_csr_rdata,
    output logic            o_csr_illegal,
    input  logic            i_instr_retire,
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_cause,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic [XLEN-1:0] i_trap_tval,
    input  logic            i_mret,
    output logic [XLEN-1:0] o_trap_vector,
    output logic [XLEN-1:0] o_mepc,
    input  logic            i_timer_int,
    input  logic            i_soft_int,
    input  logic            i_ext_int,
    output logic            o_int_req,
    output logic [XLEN-1:0] o_int_cause
);

    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mie_reg_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q, mcountinhibit_q;
    logic [63:0]     mcycle, minstret;
    logic [XLEN-1:0] mstatus_val, mip_next, rdata, wdata_new, mtvec_base, trap_code, pend;
    logic            implemented, is_write, csr_we;
    csr_op_e         op;

    assign op = csr_op_e'(i_csr_op);

    always_comb begin
        mstatus_val               = '0;
        mstatus_val[12:11]        = 2'b11;
        mstatus_val[MSTATUS_MPIE] = mpie_q;
        mstatus_val[MSTATUS_MIE]  = mie_q;
        mip_next                  = '0;
        mip_next[IRQ_MSI]         = i_soft_int;
        mip_next[IRQ_MTI]         = i_timer_int;
        mip_next[IRQ_MEI]         = i_ext_int;
    end

    always_comb begin
        rdata       = '0;
        implemented = 1'b1;
        case (i_csr_addr)
            CSR_MSTATUS:       rdata = mstatus_val;
            CSR_MIE:           rdata = mie_reg_q;
            CSR_MTVEC:         rdata = mtvec_q;
            CSR_MCOUNTINHIBIT: rdata = mcountinhibit_q;
            CSR_MSCRATCH:      rdata = mscratch_q;
            CSR_MEPC:          rdata = mepc_q;
            CSR_MCAUSE:        rdata = mcause_q;
            CSR_MTVAL:         rdata = mtval_q;
            CSR_MIP:           rdata = mip_q;
            CSR_MCYCLE:        rdata = mcycle[XLEN-1:0];
            CSR_MINSTRET:      rdata = minstret[XLEN-1:0];
            CSR_MHARTID:       rdata = XLEN'(HART_ID);
            CSR_MCYCLEH: begin
                if (XLEN == 32) rdata = mcycle[63:64-XLEN];
                else            implemented = 1'b0;
            end
            CSR_MINSTRETH: begin
                if (XLEN == 32) rdata = minstret[63:64-XLEN];
                else            implemented = 1'b0;
            end
            default:           implemented = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read, so it may target read-only CSRs.
    always_comb begin
        is_write = (op == CSR_RW) || ((op != CSR_NONE) && (i_csr_wdata != '0));
        case (op)
            CSR_RW:  wdata_new = i_csr_wdata;
            CSR_RS:  wdata_new = rdata | i_csr_wdata;
            CSR_RC:  wdata_new = rdata & ~i_csr_wdata;
            default: wdata_new = rdata;
        endcase
    end

    assign o_csr_rdata   = rdata;
    assign o_csr_illegal = (op != CSR_NONE) && (!implemented || (is_write && i_csr_addr == CSR_MHARTID));
    assign csr_we        = is_write && !o_csr_illegal && !i_trap_valid && !i_mret;

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q           <= 1'b0;
            mpie_q          <= 1'b0;
            mie_reg_q       <= '0;
            mtvec_q         <= '0;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            mtval_q         <= '0;
            mip_q           <= '0;
            mcountinhibit_q <= '0;
        end else begin
            mip_q <= mip_next;
            if (i_trap_valid) begin
                mepc_q   <= {i_trap_pc[XLEN-1:2], 2'b00};
                mcause_q <= i_trap_cause;
                mtval_q  <= i_trap_tval;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (i_mret) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end else if (csr_we) begin
                case (i_csr_addr)
                    CSR_MSTATUS: begin
                        mie_q  <= wdata_new[MSTATUS_MIE];
                        mpie_q <= wdata_new[MSTATUS_MPIE];
                    end
                    CSR_MIE:           mie_reg_q       <= wdata_new & MIE_MASK[XLEN-1:0];
                    // MODE 2/3 are reserved: keep the previous mode.
                    CSR_MTVEC:         mtvec_q         <= {wdata_new[XLEN-1:2],
                                                           wdata_new[1] ? mtvec_q[1:0] : wdata_new[1:0]};
                    CSR_MCOUNTINHIBIT: mcountinhibit_q <= wdata_new & MCOUNTINHIBIT_MASK[XLEN-1:0];
                    CSR_MSCRATCH:      mscratch_q      <= wdata_new;
                    CSR_MEPC:          mepc_q          <= {wdata_new[XLEN-1:2], 2'b00};
                    CSR_MCAUSE:        mcause_q        <= wdata_new;
                    CSR_MTVAL:         mtval_q         <= wdata_new;
                    default: ;
                endcase
            end
        end
    end

    ysyx_210238_csr_counter #(.XLEN(XLEN)) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc     (1'b1),
        .inhibit (mcountinhibit_q[CNT_CY]),
        .wr_lo   (csr_we && i_csr_addr == CSR_MCYCLE),
        .wr_hi   (csr_we && i_csr_addr == CSR_MCYCLEH),
        .wdata   (wdata_new),
        .value   (mcycle)
    );

    ysyx_210238_csr_counter #(.XLEN(XLEN)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc     (i_instr_retire),
        .inhibit (mcountinhibit_q[CNT_IR]),
        .wr_lo   (csr_we && i_csr_addr == CSR_MINSTRET),
        .wr_hi   (csr_we && i_csr_addr == CSR_MINSTRETH),
        .wdata   (wdata_new),
        .value   (minstret)
    );

    assign mtvec_base    = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_code     = {1'b0, i_trap_cause[XLEN-2:0]};
    assign o_trap_vector = (mtvec_q[1:0] == 2'b01 && i_trap_cause[XLEN-1]) ?
                           mtvec_base + (trap_code << 2) : mtvec_base;
    assign o_mepc        = mepc_q;

    assign pend      = mip_q & mie_reg_q;
    assign o_int_req = mie_q && (pend != '0);

    always_comb begin
        o_int_cause = '0;
        if (pend[IRQ_MEI])      o_int_cause = {1'b1, (XLEN-1)'(IRQ_MEI)};
        else if (pend[IRQ_MSI]) o_int_cause = {1'b1, (XLEN-1)'(IRQ_MSI)};
        else if (pend[IRQ_MTI]) o_int_cause = {1'b1, (XLEN-1)'(IRQ_MTI)};
    end

endmodule

// File: tb/tb_ysyx_210238_csr_unit.sv
// tb/tb_ysyx_210238_csr_unit.sv - scoreboard bench for the CSR unit against a behavioural model
module tb_ysyx_210238_csr_unit;

    localparam int          XLEN    = 64;
    localparam int unsigned HART_ID = 5;
    localparam logic [63:0] MSB     = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  op = '0;
    logic [11:0] addr = '0;
    logic [63:0] wdata = '0, cause = '0, pc = '0, tval = '0;
    logic        retire = 1'b0, trap = 1'b0, mret = 1'b0, tint = 1'b0, sint = 1'b0, eint = 1'b0;
    logic [63:0] rdata, vector, mepc_o, int_cause;
    logic        illegal, int_req;

    ysyx_210238_csr_unit #(.XLEN(XLEN), .HART_ID(HART_ID)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_csr_op       (op),
        .i_csr_addr     (addr),
        .i_csr_wdata    (wdata),
        .o_csr_rdata    (rdata),
        .o_csr_illegal  (illegal),
        .i_instr_retire (retire),
        .i_trap_valid   (trap),
        .i_trap_cause   (cause),
        .i_trap_pc      (pc),
        .i_trap_tval    (tval),
        .i_mret         (mret),
        .o_trap_vector  (vector),
        .o_mepc         (mepc_o),
        .i_timer_int    (tint),
        .i_soft_int     (sint),
        .i_ext_int      (eint),
        .o_int_req      (int_req),
        .o_int_cause    (int_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        illegal;
        logic        int_req;
        logic [63:0] int_cause;
        logic [63:0] vector;
        logic [63:0] mepc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: architectural CSR values as the programmer sees them.
    logic        m_ie, m_pie;
    logic [63:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip, m_cinh, m_cycle, m_instret;
    bit          use_const = 0;
    logic [63:0] const_val = '0;

    function automatic logic [63:0] mread(input logic [11:0] a, output bit ok);
        ok = 1;
        case (a)
            12'h300: return 64'h1800 + (m_pie ? 64'h80 : 0) + (m_ie ? 64'h8 : 0);
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h320: return m_cinh;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip;
            12'hB00: return m_cycle;
            12'hB02: return m_instret;
            12'hF14: return 64'(HART_ID);
            default: begin ok = 0; return 0; end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("rdata",     rdata,      e.rdata);
                check("illegal",   64'(illegal), 64'(e.illegal));
                check("int_req",   64'(int_req), 64'(e.int_req));
                check("int_cause", int_cause,  e.int_cause);
                check("vector",    vector,     e.vector);
                check("mepc",      mepc_o,     e.mepc);
            end
        end
    end

    task automatic step();
        exp_t        e;
        bit          ok;
        logic [63:0] old, nv, pend, base;
        logic        wr, ill;
        logic        n_ie, n_pie;
        logic [63:0] n_mie, n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval, n_cinh, n_cycle, n_instret;
        old  = mread(addr, ok);
        wr   = (op == 2'b01) || (op != 2'b00 && wdata != 0);
        ill  = (op != 2'b00) && (!ok || (wr && addr == 12'hF14));
        nv   = (op == 2'b01) ? wdata : (op == 2'b10) ? (old | wdata) : (old & ~wdata);
        pend = m_mip & m_mie;
        base = m_mtvec - (m_mtvec % 4);
        e.rdata     = use_const ? const_val : old;
        e.illegal   = ill;
        e.int_req   = m_ie && (pend != 0);
        e.int_cause = pend[11] ? MSB + 11 : pend[3] ? MSB + 3 : pend[7] ? MSB + 7 : 0;
        e.vector    = (m_mtvec % 4 == 1 && cause[63]) ? base + 4 * (cause & ~MSB) : base;
        e.mepc      = m_mepc;
        if (!rst) q.push_back(e);
        use_const = 0;

        n_ie = m_ie; n_pie = m_pie; n_mie = m_mie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
        n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval; n_cinh = m_cinh;
        n_cycle   = m_cinh[0] ? m_cycle : m_cycle + 1;
        n_instret = (retire && !m_cinh[2]) ? m_instret + 1 : m_instret;
        if (trap) begin
            n_mepc = pc - (pc % 4); n_mcause = cause; n_mtval = tval; n_pie = m_ie; n_ie = 0;
        end else if (mret) begin
            n_ie = m_pie; n_pie = 1;
        end else if (wr && !ill) begin
            case (addr)
                12'h300: begin n_ie = nv[3]; n_pie = nv[7]; end
                12'h304: n_mie = nv & 64'h888;
                12'h305: n_mtvec = (nv % 4 >= 2) ? nv - (nv % 4) + (m_mtvec % 4) : nv;
                12'h320: n_cinh = nv & 64'h5;
                12'h340: n_mscratch = nv;
                12'h341: n_mepc = nv - (nv % 4);
                12'h342: n_mcause = nv;
                12'h343: n_mtval = nv;
                12'hB00: n_cycle = nv;
                12'hB02: n_instret = nv;
                default: ;
            endcase
        end
        if (rst) begin
            n_ie = 0; n_pie = 0; n_mie = 0; n_mtvec = 0; n_mscratch = 0; n_mepc = 0;
            n_mcause = 0; n_mtval = 0; n_cinh = 0; n_cycle = 0; n_instret = 0;
        end
        @(posedge clk);
        #1;
        m_ie = n_ie; m_pie = n_pie; m_mie = n_mie; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
        m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval; m_cinh = n_cinh;
        m_cycle = n_cycle; m_instret = n_instret;
        m_mip = rst ? 0 : ((eint ? 64'h800 : 0) + (tint ? 64'h80 : 0) + (sint ? 64'h8 : 0));
    endtask

    task automatic csr(input logic [1:0] o, input logic [11:0] a, input logic [63:0] d);
        op = o; addr = a; wdata = d;
        step();
        op = 2'b00; wdata = '0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [63:0] exp);
        use_const = 1; const_val = exp;
        csr(2'b10, a, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] addrs[14];
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'h344, 12'h320, 12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'hB80};
        m_mip = 0;
        step();
        step();
        rst = 1'b0;

        rd(12'h300, 64'h1800);
        rd(12'hF14, 64'd5);
        rd(12'h304, 0); rd(12'h305, 0); rd(12'h340, 0); rd(12'h341, 0);
        rd(12'h342, 0); rd(12'h343, 0); rd(12'h344, 0); rd(12'h320, 0);
        rd(12'hB02, 0);
        csr(2'b10, 12'h7C0, 0);

        csr(2'b01, 12'h304, 64'hFFFF_FFFF);
        rd(12'h304, 64'h888);
        csr(2'b11, 12'h304, 64'h80);
        rd(12'h304, 64'h808);
        csr(2'b01, 12'h344, 64'h888);
        rd(12'h344, 0);
        csr(2'b01, 12'hF14, 64'h1);

        csr(2'b10, 12'h300, 64'h8);
        csr(2'b01, 12'h304, 64'h80);
        tint = 1'b1;
        step();
        rd(12'h344, 64'h80);
        csr(2'b01, 12'h304, 64'h880);
        eint = 1'b1;
        step();
        rd(12'h344, 64'h880);
        tint = 1'b0; eint = 1'b0;
        step();

        csr(2'b01, 12'h305, 64'h8000_0001);
        trap = 1'b1; cause = MSB + 7; pc = 64'h8000_1236; tval = 64'h1234_5678;
        step();
        trap = 1'b0;
        rd(12'h341, 64'h8000_1234);
        rd(12'h300, 64'h1880);
        rd(12'h343, 64'h1234_5678);
        mret = 1'b1; step(); mret = 1'b0;
        rd(12'h300, 64'h1888);
        csr(2'b01, 12'h305, 64'h1002);
        rd(12'h305, 64'h1001);

        trap = 1'b1; cause = 64'd2; pc = 64'h4000_0003;
        csr(2'b01, 12'h340, 64'hDEAD);
        trap = 1'b0;
        rd(12'h340, 0);
        rd(12'h342, 64'd2);

        retire = 1'b1;
        csr(2'b01, 12'h320, 64'h5);
        csr(2'b10, 12'hB00, 0);
        csr(2'b10, 12'hB02, 0);
        csr(2'b10, 12'hB00, 0);
        csr(2'b01, 12'hB00, '1);
        csr(2'b01, 12'h320, 64'h0);
        rd(12'hB00, '1);
        rd(12'hB00, 0);
        retire = 1'b0;

        rst = 1'b1;
        csr(2'b01, 12'h340, 64'h55);
        rst = 1'b0;
        rd(12'hB00, 0);
        rd(12'h340, 0);

        for (int i = 0; i < 600; i++) begin
            op     = 2'($urandom_range(0, 3));
            addr   = addrs[$urandom_range(0, 13)];
            wdata  = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            trap   = ($urandom_range(0, 15) == 0);
            cause  = {1'($urandom_range(0, 1)), 59'h0, 4'($urandom_range(0, 15))};
            pc     = {$urandom, $urandom};
            tval   = {$urandom, $urandom};
            mret   = ($urandom_range(0, 15) == 0);
            retire = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) tint = ~tint;
            if ($urandom_range(0, 3) == 0) sint = ~sint;
            if ($urandom_range(0, 3) == 0) eint = ~eint;
            step();
        end
        op = '0; trap = 1'b0; mret = 1'b0;

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #6;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
